// File: rtl/fetch_pkg.sv
// Shared constants and buffer entry type for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INC    = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear; used for pending PCs and fetched words.
module fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i & ~clear_i & (cnt_q != CW'(DEPTH));
    assign do_pop  = pop_i & ~clear_i & (cnt_q != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_q + {{(CW-1){1'b0}}, do_push}
                           - {{(CW-1){1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, response buffer.
// Optional FETCH_PERF_CNT_EN adds fetch/drop performance counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_pc_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_gnt_in,
    input  logic        imem_rvalid_in,
    input  logic [31:0] imem_rdata_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid_out,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_cnt_out,
    output logic [31:0] drop_cnt_out,
`endif
    output logic        flush_out
);

    localparam int            CW     = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0]   CREDIT = (CW+1)'(BUF_DEPTH);

    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_last_q;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] pend_cnt;
    logic [CW-1:0] buf_cnt;
    logic [31:0]  pend_head;
    logic [CW:0]  credit_use;
    logic         fire;
    logic         rsp_ok;
    logic         rsp_keep;
    logic         pop;
    fetch_entry_t buf_in;
    fetch_entry_t buf_head;
    logic         unused_pc_lsb;

    assign unused_pc_lsb = ^branch_pc_in[1:0];

    // Credit covers both outstanding requests and buffered words.
    assign credit_use = {1'b0, pend_cnt} + {1'b0, buf_cnt} + (CW+1)'(1);

    assign imem_req_out  = rst_in & ~branch_taken_in & (credit_use <= CREDIT);
    assign imem_addr_out = pc_q;

    assign fire     = imem_req_out & imem_gnt_in;
    assign rsp_ok   = imem_rvalid_in & (pend_cnt != '0);
    assign rsp_keep = rsp_ok & (drop_q == '0) & ~branch_taken_in;
    assign pop      = instr_valid_out & ~stall_in & ~branch_taken_in;
    assign buf_in   = {pend_head, imem_rdata_in};

    always_comb begin
        pc_d = pc_q;
        if (branch_taken_in) pc_d = {branch_pc_in[31:2], 2'b00};
        else if (fire)       pc_d = pc_q + PC_INC;
    end

    // Pending count already includes earlier drops, so a redirect just
    // re-arms the drop counter with everything still outstanding.
    always_comb begin
        drop_d = drop_q;
        if (branch_taken_in)
            drop_d = pend_cnt - {{(CW-1){1'b0}}, rsp_ok};
        else if (rsp_ok && drop_q != '0)
            drop_d = drop_q - CW'(1);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            pc_q      <= RESET_PC;
            drop_q    <= '0;
            pc_last_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
            if (instr_valid_out) pc_last_q <= buf_head.pc;
        end
    end

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (BUF_DEPTH)
    ) u_pend (
        .clk_i   (clk_in),
        .rst_ni  (rst_in),
        .push_i  (fire),
        .pop_i   (rsp_ok),
        .clear_i (1'b0),
        .data_i  (pc_q),
        .head_o  (pend_head),
        .count_o (pend_cnt)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk_i   (clk_in),
        .rst_ni  (rst_in),
        .push_i  (rsp_keep),
        .pop_i   (pop),
        .clear_i (branch_taken_in),
        .data_i  (buf_in),
        .head_o  (buf_head),
        .count_o (buf_cnt)
    );

    assign instr_valid_out = buf_cnt != '0;
    assign instr_out = instr_valid_out ? buf_head.instr : NOP_INSTR;
    assign pc_out    = instr_valid_out ? buf_head.pc : pc_last_q;
    assign flush_out = ~instr_valid_out | branch_taken_in;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] drop_perf_q;
    logic [31:0] drop_inc;

    always_comb begin
        drop_inc = 32'(rsp_ok & (branch_taken_in | (drop_q != '0)));
        if (branch_taken_in) drop_inc = drop_inc + 32'(buf_cnt);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            fetch_cnt_q <= '0;
            drop_perf_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_q + 32'(pop);
            drop_perf_q <= drop_perf_q + drop_inc;
        end
    end

    assign fetch_cnt_out = fetch_cnt_q;
    assign drop_cnt_out  = drop_perf_q;
`endif

    rsp_without_req_a: assert property (
        @(posedge clk_in) disable iff (!rst_in)
        imem_rvalid_in |-> (pend_cnt != '0)
    );

endmodule
